// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared types and helpers for the line rasteriser
// Contents: state_t engine states, MASK_NONE, pixel_mask() byte-mask helper,
// burst_addr() frame-buffer address composition.
package gfx_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, BEAT0, BEAT1, DONE} state_t;

    localparam logic [15:0] MASK_NONE = 16'hFFFF;

    // Byte mask for one 128-bit beat of an 8-pixel burst (1 = byte not written).
    // beat 0 holds pixels 0..3, beat 1 pixels 4..7; lane 0 sits in bytes 15:12.
    function automatic logic [15:0] pixel_mask(input logic [2:0] px_lo, input logic beat);
        logic [15:0] m;
        m = MASK_NONE;
        if (px_lo[2] == beat)
            m = MASK_NONE & ~(16'hF000 >> {px_lo[1:0], 2'b00});
        return m;
    endfunction

    // base + row offset + burst column; one burst covers 8 pixels / 4 address units.
    function automatic logic [30:0] burst_addr(input logic [30:0] base, input logic [15:0] px,
                                               input logic [15:0] py, input int unsigned row_shift);
        logic [30:0] row;
        logic [30:0] col;
        row = 31'(py) << row_shift;
        col = {16'd0, px[15:3], 2'b00};
        return base + row + col;
    endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// rtl/bresenham_stepper.sv - Bresenham walker along the major axis
// Ports: clk, rst (sync, active-high); load + load_* SETUP values;
// step advances one pixel; px/py current plot point, last = final pixel.
module bresenham_stepper
    import gfx_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic [COORD_W-1:0] load_x1,
    input  logic [COORD_W:0]   load_dx,
    input  logic [COORD_W:0]   load_dy,
    input  logic               load_steep,
    input  logic               load_ystep_neg,
    input  logic               step,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               last
);
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    logic [COORD_W-1:0]        x, y, x1;
    logic [COORD_W:0]          dx, dy;
    logic                      steep, ystep_neg;
    logic signed [COORD_W+1:0] err, err_dec, dx_s, dy_s;

    assign dx_s    = $signed({1'b0, dx});
    assign dy_s    = $signed({1'b0, dy});
    assign err_dec = err - dy_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            x1        <= '0;
            dx        <= '0;
            dy        <= '0;
            steep     <= 1'b0;
            ystep_neg <= 1'b0;
            err       <= '0;
        end else if (load) begin
            x         <= load_x;
            y         <= load_y;
            x1        <= load_x1;
            dx        <= load_dx;
            dy        <= load_dy;
            steep     <= load_steep;
            ystep_neg <= load_ystep_neg;
            err       <= $signed({2'b00, load_dx[COORD_W:1]});
        end else if (step) begin
            x <= x + ONE;
            if (err_dec < 0) begin
                y   <= ystep_neg ? y - ONE : y + ONE;
                err <= err_dec + dx_s;
            end else begin
                err <= err_dec;
            end
        end
    end

    // Walk happens in the swapped frame; undo the swap for steep lines.
    assign px   = steep ? y : x;
    assign py   = steep ? x : y;
    assign last = (x == x1);

endmodule

// File: rtl/line_engine_v2.sv
// rtl/line_engine_v2.sv - Bresenham line rasteriser feeding the DDR af/wdf FIFOs
// Ports: clk, rst (sync, active-high); cmd_* line command with valid/ready;
// af_* address FIFO push; wdf_* write-data FIFO push (2 beats per pixel);
// busy while a line is in flight, done pulses once after the last beat.
// Build option: LINE_ENGINE_CLIP_EN skips pixels outside SCREEN_W x SCREEN_H.
module line_engine_v2
    import gfx_pkg::*;
#(
    parameter int COORD_W   = 10,
    parameter int ROW_SHIFT = 9,
    parameter int SCREEN_W  = 800,
    parameter int SCREEN_H  = 600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic [31:0]        cmd_color,
    input  logic [30:0]        cmd_frame_base,
    input  logic               af_full,
    output logic               af_wr_en,
    output logic [30:0]        af_addr_din,
    input  logic               wdf_full,
    output logic               wdf_wr_en,
    output logic [127:0]       wdf_din,
    output logic [15:0]        wdf_mask_din,
    output logic               busy,
    output logic               done
);
`ifdef LINE_ENGINE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_t             state, state_nx;
    logic [COORD_W-1:0] x0_r, y0_r, x1_r, y1_r;
    logic [31:0]        color_r;
    logic [30:0]        base_r;

    logic               load, step, last, clipped, off_screen;
    logic [COORD_W-1:0] px, py;

    // SETUP arithmetic, all from the registered command.
    logic [COORD_W:0]   adx, ady;
    logic               steep, swap;
    logic [COORD_W-1:0] a0, b0, a1, b1, sx0, sy0, sx1, sy1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x0_r    <= '0;
            y0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            color_r <= '0;
            base_r  <= '0;
        end else begin
            state <= state_nx;
            if (cmd_valid && cmd_ready) begin
                x0_r    <= cmd_x0;
                y0_r    <= cmd_y0;
                x1_r    <= cmd_x1;
                y1_r    <= cmd_y1;
                color_r <= cmd_color;
                base_r  <= cmd_frame_base;
            end
        end
    end

    assign adx   = (x1_r >= x0_r) ? ({1'b0, x1_r} - {1'b0, x0_r}) : ({1'b0, x0_r} - {1'b0, x1_r});
    assign ady   = (y1_r >= y0_r) ? ({1'b0, y1_r} - {1'b0, y0_r}) : ({1'b0, y0_r} - {1'b0, y1_r});
    assign steep = ady > adx;
    assign a0    = steep ? y0_r : x0_r;
    assign b0    = steep ? x0_r : y0_r;
    assign a1    = steep ? y1_r : x1_r;
    assign b1    = steep ? x1_r : y1_r;
    assign swap  = a0 > a1;
    assign sx0   = swap ? a1 : a0;
    assign sy0   = swap ? b1 : b0;
    assign sx1   = swap ? a0 : a1;
    assign sy1   = swap ? b0 : b1;

    bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .load_x         (sx0),
        .load_y         (sy0),
        .load_x1        (sx1),
        .load_dx        (steep ? ady : adx),
        .load_dy        (steep ? adx : ady),
        .load_steep     (steep),
        .load_ystep_neg (!(sy0 < sy1)),
        .step           (step),
        .px             (px),
        .py             (py),
        .last           (last)
    );

    assign off_screen = (32'(px) >= 32'(SCREEN_W)) || (32'(py) >= 32'(SCREEN_H));
    assign clipped    = CLIP_EN && off_screen;

    always_comb begin
        state_nx     = state;
        load         = 1'b0;
        step         = 1'b0;
        af_wr_en     = 1'b0;
        wdf_wr_en    = 1'b0;
        af_addr_din  = '0;
        wdf_mask_din = MASK_NONE;
        done         = 1'b0;
        case (state)
            IDLE: if (cmd_valid) state_nx = SETUP;
            SETUP: begin
                load     = 1'b1;
                state_nx = BEAT0;
            end
            BEAT0: begin
                if (clipped) begin
                    // Off-screen pixel: no pushes, advance in the same cycle.
                    if (last) state_nx = DONE;
                    else      step     = 1'b1;
                end else begin
                    af_addr_din  = burst_addr(base_r, 16'(px), 16'(py), ROW_SHIFT);
                    wdf_mask_din = pixel_mask(px[2:0], 1'b0);
                    // af and wdf push together so the burst never splits across FIFOs.
                    af_wr_en     = !af_full && !wdf_full;
                    wdf_wr_en    = !af_full && !wdf_full;
                    if (af_wr_en) state_nx = BEAT1;
                end
            end
            BEAT1: begin
                af_addr_din  = burst_addr(base_r, 16'(px), 16'(py), ROW_SHIFT);
                wdf_mask_din = pixel_mask(px[2:0], 1'b1);
                wdf_wr_en    = !wdf_full;
                if (wdf_wr_en) begin
                    if (last) begin
                        state_nx = DONE;
                    end else begin
                        step     = 1'b1;
                        state_nx = BEAT0;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wdf_din   = {4{color_r}};

endmodule

// File: tb/tb_line_engine_v2.sv
// tb/tb_line_engine_v2.sv - self-checking bench for line_engine_v2
module tb_line_engine_v2;
    localparam int SW = 800;
    localparam int SH = 600;

    logic         clk = 1'b0;
    logic         rst, cmd_valid, cmd_ready;
    logic [9:0]   cmd_x0, cmd_y0, cmd_x1, cmd_y1;
    logic [31:0]  cmd_color;
    logic [30:0]  cmd_frame_base;
    logic         af_full, af_wr_en, wdf_full, wdf_wr_en, busy, done;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    always #5 clk = ~clk;

    line_engine_v2 #(.COORD_W(10), .ROW_SHIFT(9), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .cmd_frame_base(cmd_frame_base),
        .af_full(af_full), .af_wr_en(af_wr_en), .af_addr_din(af_addr_din),
        .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din),
        .wdf_mask_din(wdf_mask_din), .busy(busy), .done(done)
    );

    int checks = 0;
    int failures = 0;
    int cyc_idx = 0;
    int exp_cycles, last_lat, pe0, de0;
    int proto_err = 0;
    int data_err = 0;
    logic [31:0] cur_color = '0;
    logic [30:0] exp_addr[$], got_addr[$], save_addr[$];
    logic [16:0] exp_w[$], got_w[$], save_w[$];

    // Observe pushes away from the active edge; {af pushed this cycle, mask}.
    always @(negedge clk) begin
        if (!rst) begin
            if (af_wr_en && (!wdf_wr_en || af_full)) proto_err++;
            if (wdf_wr_en && wdf_full) proto_err++;
            if (af_wr_en) got_addr.push_back(af_addr_din);
            if (wdf_wr_en) begin
                got_w.push_back({af_wr_en, wdf_mask_din});
                if (wdf_din !== {4{cur_color}}) data_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_idx++;
    endtask

    // Reference: pixel list from the line rules, then the FIFO traffic it implies.
    function automatic void build_expect(input int ax0, input int ay0, input int ax1, input int ay1,
                                         input logic [30:0] base);
        int x0, y0, x1, y1, t, dx, dy, err, ystep, y, px, py, lane;
        bit steep, off;
        longint a;
        logic [15:0] m0, m1;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        exp_addr.delete();
        exp_w.delete();
        exp_cycles = 2;
        steep = ((y1 > y0) ? y1 - y0 : y0 - y1) > ((x1 > x0) ? x1 - x0 : x0 - x1);
        if (steep) begin
            t = x0; x0 = y0; y0 = t;
            t = x1; x1 = y1; y1 = t;
        end
        if (x0 > x1) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
        dx = x1 - x0;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        ystep = (y0 < y1) ? 1 : -1;
        err = dx / 2;
        y = y0;
        for (int x = x0; x <= x1; x++) begin
            px = steep ? y : x;
            py = steep ? x : y;
`ifdef LINE_ENGINE_CLIP_EN
            off = (px >= SW) || (py >= SH);
`else
            off = 1'b0;
`endif
            if (off) begin
                exp_cycles += 1;
            end else begin
                a = longint'(base) + (longint'(py) << 9) + longint'((px / 8) * 4);
                exp_addr.push_back(a[30:0]);
                lane = px % 8;
                for (int b = 0; b < 16; b++) begin
                    m0[b] = !(lane < 4 && (3 - b / 4) == lane);
                    m1[b] = !(lane >= 4 && (3 - b / 4) == lane - 4);
                end
                exp_w.push_back({1'b1, m0});
                exp_w.push_back({1'b0, m1});
                exp_cycles += 2;
            end
            err -= dy;
            if (err < 0) begin
                y += ystep;
                err += dx;
            end
        end
    endfunction

    task automatic start_line(input int x0, input int y0, input int x1, input int y1,
                              input logic [31:0] color, input logic [30:0] base);
        build_expect(x0, y0, x1, y1, base);
        got_addr.delete();
        got_w.delete();
        pe0 = proto_err;
        de0 = data_err;
        cur_color = color;
        check("ready before accept", cmd_ready, 1);
        cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_x1 = 10'(x1); cmd_y1 = 10'(y1);
        cmd_color = color;
        cmd_frame_base = base;
        cmd_valid = 1'b1;
        cyc_idx = 0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_line(input string tag, input bit stall, input bit chk_lat);
        int bad_a, bad_w;
        while (done !== 1'b1 && cyc_idx < 20000) begin
            if (stall) begin
                af_full  = ($urandom_range(0, 2) == 0);
                wdf_full = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        af_full = 1'b0;
        wdf_full = 1'b0;
        last_lat = cyc_idx;
        check({tag, " done seen"}, done, 1);
        if (chk_lat) check({tag, " latency"}, last_lat, exp_cycles);
        check({tag, " af count"}, got_addr.size(), exp_addr.size());
        check({tag, " wdf count"}, got_w.size(), exp_w.size());
        bad_a = -1;
        bad_w = -1;
        for (int i = 0; i < exp_addr.size(); i++)
            if (bad_a < 0 && (i >= got_addr.size() || got_addr[i] !== exp_addr[i])) bad_a = i;
        for (int i = 0; i < exp_w.size(); i++)
            if (bad_w < 0 && (i >= got_w.size() || got_w[i] !== exp_w[i])) bad_w = i;
        if (bad_a >= 0 && bad_a < got_addr.size())
            $display("  %s addr idx %0d got %h exp %h", tag, bad_a, got_addr[bad_a], exp_addr[bad_a]);
        if (bad_w >= 0 && bad_w < got_w.size())
            $display("  %s beat idx %0d got %h exp %h", tag, bad_w, got_w[bad_w], exp_w[bad_w]);
        check({tag, " first bad addr idx"}, 64'(bad_a), 64'(-1));
        check({tag, " first bad beat idx"}, 64'(bad_w), 64'(-1));
        check({tag, " protocol errors"}, proto_err - pe0, 0);
        check({tag, " data errors"}, data_err - de0, 0);
        tick();
        check({tag, " done one cycle"}, done, 0);
        check({tag, " ready after done"}, cmd_ready, 1);
    endtask

    initial begin
        bit          ok;
        logic [30:0] base;
        rst = 1'b1; cmd_valid = 1'b0; af_full = 1'b0; wdf_full = 1'b0;
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
        cmd_color = '0; cmd_frame_base = '0;
        repeat (3) tick();
        check("reset cmd_ready", cmd_ready, 1);
        check("reset busy/done/wr", {busy, done, af_wr_en, wdf_wr_en}, 4'b0000);
        check("reset addr", af_addr_din, 0);
        check("reset mask", wdf_mask_din, 16'hFFFF);
        rst = 1'b0;
        tick();

        // Horizontal line.
        start_line(0, 0, 9, 0, 32'h00A1B2C3, 31'h0);
        finish_line("horiz", 1'b0, 1'b1);
        check("horiz latency 22", last_lat, 22);
        check("horiz addr px8", got_addr[8], 4);
        check("horiz beat0 px0", got_w[0], {1'b1, 16'h0FFF});
        check("horiz beat1 px0", got_w[1], {1'b0, 16'hFFFF});
        check("horiz beat0 px3", got_w[6], {1'b1, 16'hFFF0});

        // Steep line: one pixel per row 2..9.
        start_line(5, 2, 3, 9, 32'h00102030, 31'h100);
        finish_line("steep", 1'b0, 1'b1);
        check("steep pixel count", got_addr.size(), 8);
        ok = 1'b1;
        for (int i = 0; i < got_addr.size(); i++)
            if (((got_addr[i] - 31'h100) >> 9) != 31'(2 + i)) ok = 1'b0;
        check("steep rows 2..9", ok, 1);

        // Reverse octant must match the forward line exactly.
        start_line(9, 9, 0, 0, 32'h00FF00FF, 31'h0);
        finish_line("reverse", 1'b0, 1'b1);
        save_addr = got_addr;
        save_w = got_w;
        check("reverse addr px7", got_addr[7], 7 << 9);
        check("reverse beat1 px7", got_w[15], {1'b0, 16'hFFF0});
        start_line(0, 0, 9, 9, 32'h00FF00FF, 31'h0);
        finish_line("forward", 1'b0, 1'b1);
        check("fwd/rev addr equal", (got_addr == save_addr), 1);
        check("fwd/rev beats equal", (got_w == save_w), 1);

        // Back-pressure: af_full over 5 BEAT0 cycles, then wdf_full over 3 BEAT1 cycles.
        af_full = 1'b1;
        start_line(0, 0, 9, 0, 32'h00445566, 31'h0);
        tick();
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (af_wr_en || wdf_wr_en || af_addr_din !== 31'h0 || wdf_mask_din !== 16'h0FFF) ok = 1'b0;
            tick();
        end
        af_full = 1'b0;
        tick();
        wdf_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (af_wr_en || wdf_wr_en || wdf_mask_din !== 16'hFFFF) ok = 1'b0;
            tick();
        end
        wdf_full = 1'b0;
        check("bp stall hold", ok, 1);
        exp_cycles += 8;
        finish_line("bp", 1'b0, 1'b1);

        // Single point.
        start_line(4, 4, 4, 4, 32'h00010203, 31'h40);
        finish_line("point", 1'b0, 1'b1);
        check("point af pushes", got_addr.size(), 1);
        check("point wdf pushes", got_w.size(), 2);

        // Reset during BEAT1 of a 10-pixel line.
        start_line(0, 0, 9, 0, 32'h00777777, 31'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midreset ready", cmd_ready, 1);
        check("midreset no pushes", {af_wr_en, wdf_wr_en, busy, done}, 4'b0000);
        check("midreset mask", wdf_mask_din, 16'hFFFF);
        check("midreset af before reset", got_addr.size(), 1);
        rst = 1'b0;
        tick();

        // Line crossing the right screen edge.
        start_line(795, 0, 805, 0, 32'h00123456, 31'h0);
        finish_line("edge", 1'b0, 1'b1);
`ifdef LINE_ENGINE_CLIP_EN
        check("edge clipped af count", got_addr.size(), 5);
`else
        check("edge unclipped af count", got_addr.size(), 11);
`endif

        // Randomised lines: odd ones short with random back-pressure, even ones full range.
        for (int n = 0; n < 24; n++) begin
            int lim;
            bit st;
            st = n[0];
            lim = st ? 40 : 1023;
            base = 31'($urandom()) & ~31'd3;
            start_line($urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                       $urandom_range(0, lim), $urandom() & 32'h00FFFFFF, base);
            finish_line(st ? "rand stall" : "rand", st, !st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_engine_v2.md
Name: line_engine_v2

Overview:
- Parametrised Bresenham line rasteriser for the DDR frame-buffer path.
- Accepts one line command per handshake: endpoints, colour and frame base. Handles all eight octants.
- For each pixel it emits one address-FIFO entry plus two 128-bit write-data beats, which together form one 8-pixel (256-bit) burst with a per-byte mask.
- Sits between the command/MMIO decoder and the memory-controller af/wdf FIFOs.

Parameters:
- COORD_W, 10, width of each coordinate in bits.
- ROW_SHIFT, 9, log2 of the address stride per frame row (address units).
- SCREEN_W, 800, visible width in pixels; used only by the clipping feature.
- SCREEN_H, 600, visible height in pixels; used only by the clipping feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd_valid  in  1  line command valid
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  endpoints, unsigned
- cmd_color  in  32  {8'h00, R, G, B}
- cmd_frame_base  in  31  frame base address, burst-aligned (bits [1:0] = 0)
- af_full  in  1  address FIFO full
- af_wr_en  out  1  address FIFO push
- af_addr_din  out  31  burst address
- wdf_full  in  1  write-data FIFO full
- wdf_wr_en  out  1  write-data FIFO push
- wdf_din  out  128  colour replicated ×4
- wdf_mask_din  out  16  byte mask, 1 = byte not written
- busy  out  1  line in progress
- done  out  1  one-cycle pulse after the last pixel's second beat

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - Reset forces state IDLE and clears all outputs: af_wr_en=0, wdf_wr_en=0, done=0, busy=0, af_addr_din=0, wdf_mask_din=16'hFFFF.
  - cmd_ready=1 out of reset.
  - Reset mid-line abandons the line immediately, including a half-written burst.
- Command capture: when cmd_valid && cmd_ready, all cmd_* fields are registered.
  - cmd_ready = (state==IDLE).
- States:
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle):
    - steep = |dy| > |dx|; when steep, swap x<->y on both endpoints.
    - Then, if x0 > x1, swap the two endpoints.
    - dx = x1-x0; dy = |y1-y0|; ystep = +1 if y0 < y1, else -1.
    - err = dx>>1; x = x0; y = y0.
    - SETUP -> BEAT0.
  - BEAT0:
    - Plot point: (px,py) = steep ? (y,x) : (x,y).
    - af_wr_en = wdf_wr_en = !af_full && !wdf_full; both assert in the same cycle or neither does.
    - af_addr_din = cmd_frame_base + (py << ROW_SHIFT) + {px[COORD_W-1:3], 2'b00}, truncated to 31 bits.
    - Beat 0 carries pixels px[2:0] = 0..3; pixel 0 occupies bytes 15:12, pixel 3 bytes 3:0. The selected pixel's nibble of the mask is 0, all other bits 1; mask is 16'hFFFF if px[2]=1.
    - On push -> BEAT1; otherwise stay in BEAT0 with outputs stable.
  - BEAT1:
    - wdf_wr_en = !wdf_full; af_wr_en = 0.
    - Mask covers pixels 4..7 with the same nibble mapping; 16'hFFFF if px[2]=0.
    - On push:
      - If x == x1 -> DONE.
      - Else x += 1; err' = err - dy; if err' < 0 then y += ystep and err' += dx; -> BEAT0.
    - Otherwise hold.
  - DONE: done=1 for one cycle -> IDLE.
- Arithmetic: err is signed COORD_W+2 bits. dx, dy are COORD_W+1 bits, computed before swapping.
- Endpoints are inclusive. A zero-length line (x0=x1, y0=y1) plots exactly one pixel.
- Throughput: best case 2 cycles per pixel. Total line latency from accept to done is 2 + 2·N + stall cycles, where N = max(|dx|,|dy|)+1.
- Every accepted af entry is followed by exactly one beat-1 wdf push before any further af push.
- wdf_din = {cmd_color ×4}, registered at accept and constant for the whole line.
- busy = (state != IDLE).

Optional Feature:
- Macro LINE_ENGINE_CLIP_EN.
- Defined: a pixel with px >= SCREEN_W or py >= SCREEN_H skips both beats. In BEAT0 it does not push; the Bresenham step occurs immediately in that cycle and the engine stays in BEAT0, or goes to DONE if it was the last pixel. Each clipped pixel costs 1 cycle. A fully clipped line still pulses done.
- Undefined: every pixel is written; addresses of off-screen pixels wrap per the address formula.

Decomposition:
- Shared package gfx_pkg holds:
  - state enum: IDLE, SETUP, BEAT0, BEAT1, DONE
  - MASK_NONE = 16'hFFFF
  - pixel-to-nibble mask function
  - address-composition function (base, px, py, ROW_SHIFT)
- Natural sub-module: bresenham_stepper. It owns x, y, err, the steep and ystep flags, and the last-pixel flag. Interface: load from SETUP values, step strobe, and (px,py,last) outputs.

Test Plan:
- Horizontal line (0,0)-(9,0), base 0, FIFOs never full: af addresses 0,0,…(8 pixels),4,4. Masks alternate between beat0 (0FFF, F0FF, FF0F, FFF0) and beat1 FFFF per pixel. done after 22 cycles.
- Steep line (5,2)-(3,9): exactly 8 pixels, y from 2 to 9; x moves monotonically 5→3. No duplicate or missing rows.
- Reverse-octant line (9,9)-(0,0): identical pixel set to (0,0)-(9,9). Pixel (7,7) gives address (7<<9)+0 with beat1 mask FFF0.
- Back-pressure: assert af_full for 5 cycles during BEAT0, then wdf_full for 3 cycles during BEAT1. No pushes occur while stalled, outputs hold, and the pixel count is unchanged.
- Single point (4,4)-(4,4): one af push and two wdf pushes, then done. Asserting rst during BEAT1 of a 10-pixel line gives cmd_ready=1 and no pushes on the next cycle.
- With LINE_ENGINE_CLIP_EN and SCREEN_W=800: line (795,0)-(805,0) issues 5 af pushes and pulses done.
